fifo_stream_adapter: RTL and testbench

FIFO_STREAM_ADAPTER -- requirements
Module: fifo_stream_adapter

---
 rtl/fifo_stream_adapter.sv | 71 +++++++
 tb/tb_fifo_stream_adapter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_adapter.sv
`timescale 1ns/1ps
// fifo_stream_adapter: drains a registered-read FIFO into a valid/ready stream
// through a 3-entry circular buffer that reserves room for the read still in flight.
module fifo_stream_adapter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] entries [3];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [1:0]            occ_q;
    logic                  in_flight;
    logic                  capture;
    logic                  pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A read is only issued when a slot is free even counting the word already in flight,
    // so backpressure never needs to reach the FIFO read path.
    assign fifo_rd_en = rst_n && en && !fifo_empty
                        && (({1'b0, occ_q} + {2'b00, in_flight}) < 3'd3);

    assign capture = in_flight;
    assign pop     = m_valid && m_ready;
    assign m_valid = (occ_q != 2'd0);
    assign m_data  = entries[rd_ptr];
    assign occ     = occ_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= 1'b0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            occ_q     <= 2'd0;
        end else begin
            in_flight <= fifo_rd_en;
            if (capture) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({capture, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Data storage is deliberately not reset; m_data is only meaningful while m_valid is high.
    always_ff @(posedge clk) begin
        if (capture) begin
            entries[wr_ptr] <= fifo_rd_data;
        end
    end

endmodule

// File: tb/tb_fifo_stream_adapter.sv
`timescale 1ns/1ps
// tb_fifo_stream_adapter: drives a modelled registered-read FIFO into the adapter and
// checks every cycle against a queue-based model of buffer occupancy and word order.
module tb_fifo_stream_adapter;

    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic [1:0]    occ;

    int nVectors = 0;
    int nMiscompares = 0;

    int            mOcc;
    bit            mF;
    logic [DW-1:0] pendWord;
    logic [DW-1:0] mBuf[$];
    logic [DW-1:0] fifoQ[$];
    logic [DW-1:0] delivered[$];
    logic [DW-1:0] sent[$];
    int            dutReads = 0;
    int            dutPops = 0;

    fifo_stream_adapter #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .occ          (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic enVal, input logic readyVal);
        en      = enVal;
        m_ready = readyVal;
    endtask

    task automatic pushWord(input logic [DW-1:0] w);
        fifoQ.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic resetModel();
        mOcc = 0;
        mF   = 1'b0;
        mBuf.delete();
    endtask

    // Per-cycle comparison of every DUT output against the model, with inputs already settled.
    task automatic compareCycle();
        logic expRd;
        expRd = rst_n && en && !fifo_empty && ((mOcc + int'(mF)) < 3);
        checkOutput("fifo_rd_en", 32'(fifo_rd_en), 32'(expRd));
        checkOutput("m_valid", 32'(m_valid), 32'(mOcc != 0));
        checkOutput("occ", 32'(occ), 32'(mOcc));
        if (mOcc != 0) begin
            checkOutput("m_data", 32'(m_data), 32'(mBuf[0]));
        end
        if (fifo_rd_en) dutReads++;
        if (rst_n && m_valid && m_ready) dutPops++;
    endtask

    // One clock: compare, then advance the model and the upstream FIFO on the edge.
    task automatic tick();
        logic rdNow;
        #1;
        compareCycle();
        @(posedge clk);
        rdNow = 1'b0;
        if (rst_n) begin
            rdNow = en && !fifo_empty && ((mOcc + int'(mF)) < 3);
            if (mOcc != 0 && m_ready) begin
                delivered.push_back(mBuf.pop_front());
                mOcc--;
            end
            if (mF) begin
                mBuf.push_back(pendWord);
                mOcc++;
            end
            mF = rdNow;
            if (rdNow) pendWord = fifoQ.pop_front();
        end
        #1;
        fifo_rd_data = rdNow ? pendWord : DW'($urandom);
        fifo_empty   = (fifoQ.size() == 0);
        @(negedge clk);
    endtask

    task automatic drain(input int n, input int budget, input string name);
        for (int i = 0; i < budget && delivered.size() < n; i++) tick();
        checkOutput({name, "_count"}, 32'(delivered.size()), 32'(n));
    endtask

    task automatic checkDelivered(input string name, input int base, input int n);
        checkOutput({name, "_size"}, 32'(delivered.size()), 32'(n));
        for (int i = 0; i < n && i < delivered.size(); i++) begin
            checkOutput({name, "_word"}, 32'(delivered[i]), 32'(base + i));
        end
    endtask

    initial begin
        int p0;
        int r0;
        logic [DW-1:0] w;

        rst_n        = 1'b1;
        fifo_rd_data = '0;
        fifo_empty   = 1'b1;
        applyStimulus(1'b1, 1'b0);
        resetModel();
        #2;
        rst_n = 1'b0;

        // Held in reset with an empty FIFO and en high: everything stays idle.
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("rst_rd_en", 32'(fifo_rd_en), 32'd0);
            checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
            checkOutput("rst_occ", 32'(occ), 32'd0);
            tick();
        end
        rst_n = 1'b1;
        tick();
        tick();

        // Five preloaded words streamed with m_ready high: latency 2, one word per cycle.
        $display("[TB] streaming 0x10..0x14");
        delivered.delete();
        for (int i = 0; i < 5; i++) pushWord(DW'(8'h10 + i));
        applyStimulus(1'b1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            #1;
            checkOutput("s5_rd_en", 32'(fifo_rd_en), 32'(k < 5));
            checkOutput("s5_m_valid", 32'(m_valid), 32'(k >= 2 && k < 7));
            if (k >= 2 && k < 7) checkOutput("s5_m_data", 32'(m_data), 32'(8'h10 + k - 2));
            tick();
        end
        checkDelivered("s5", 8'h10, 5);

        // Ten words against a stalled sink: exactly three reads, then release in order.
        $display("[TB] backpressure with 10 words");
        delivered.delete();
        for (int i = 0; i < 10; i++) pushWord(DW'(8'h20 + i));
        applyStimulus(1'b1, 1'b0);
        r0 = dutReads;
        for (int k = 0; k < 8; k++) tick();
        #1;
        checkOutput("bp_reads", 32'(dutReads - r0), 32'd3);
        checkOutput("bp_occ", 32'(occ), 32'd3);
        checkOutput("bp_rd_en", 32'(fifo_rd_en), 32'd0);
        p0 = dutPops;
        applyStimulus(1'b1, 1'b1);
        drain(10, 40, "bp");
        checkOutput("bp_pops", 32'(dutPops - p0), 32'd10);
        checkDelivered("bp", 8'h20, 10);

        // Seven words with m_ready toggling every cycle, wrapping the pointers repeatedly.
        $display("[TB] toggling ready with 7 words");
        delivered.delete();
        for (int i = 0; i < 7; i++) pushWord(DW'(8'h30 + i));
        p0 = dutPops;
        for (int k = 0; k < 60 && delivered.size() < 7; k++) begin
            applyStimulus(1'b1, k[0]);
            tick();
        end
        checkOutput("tog_count", 32'(delivered.size()), 32'd7);
        checkOutput("tog_pops", 32'(dutPops - p0), 32'd7);
        checkDelivered("tog", 8'h30, 7);

        // en dropped right after a read issues: the in-flight word is still captured.
        $display("[TB] en drop after read");
        delivered.delete();
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) pushWord(DW'(8'h40 + i));
        #1;
        checkOutput("en_off_rd_en", 32'(fifo_rd_en), 32'd0);
        applyStimulus(1'b1, 1'b0);
        #1;
        checkOutput("en_on_rd_en", 32'(fifo_rd_en), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0);
        #1;
        checkOutput("en_drop_rd_en", 32'(fifo_rd_en), 32'd0);
        checkOutput("en_drop_occ0", 32'(occ), 32'd0);
        tick();
        #1;
        checkOutput("en_drop_occ1", 32'(occ), 32'd1);
        tick();
        tick();
        #1;
        checkOutput("en_hold_occ", 32'(occ), 32'd1);
        checkOutput("en_hold_rd_en", 32'(fifo_rd_en), 32'd0);
        applyStimulus(1'b1, 1'b1);
        drain(4, 30, "en");
        checkDelivered("en", 8'h40, 4);

        // Reset pulsed between edges with two words buffered and one in flight.
        $display("[TB] mid-stream reset");
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) pushWord(DW'(8'h60 + i));
        tick();
        tick();
        tick();
        #1;
        checkOutput("mr_occ_before", 32'(occ), 32'd2);
        rst_n = 1'b0;
        resetModel();
        fifoQ.delete();
        fifo_empty = 1'b1;
        #1;
        checkOutput("mr_rd_en", 32'(fifo_rd_en), 32'd0);
        checkOutput("mr_m_valid", 32'(m_valid), 32'd0);
        checkOutput("mr_occ", 32'(occ), 32'd0);
        rst_n = 1'b1;
        delivered.delete();
        for (int i = 0; i < 3; i++) pushWord(DW'(8'h50 + i));
        p0 = dutPops;
        applyStimulus(1'b1, 1'b1);
        drain(3, 20, "mr");
        checkOutput("mr_pops", 32'(dutPops - p0), 32'd3);
        checkDelivered("mr", 8'h50, 3);

        // Randomized traffic: random refills, random en and random backpressure.
        $display("[TB] random traffic");
        delivered.delete();
        sent.delete();
        p0 = dutPops;
        for (int c = 0; c < 400; c++) begin
            if (fifoQ.size() < 6 && $urandom_range(0, 1) == 1) begin
                w = DW'($urandom);
                pushWord(w);
                sent.push_back(w);
            end
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            tick();
        end
        applyStimulus(1'b1, 1'b1);
        drain(sent.size(), 100, "rnd");
        checkOutput("rnd_pops", 32'(dutPops - p0), 32'(sent.size()));
        for (int i = 0; i < sent.size() && i < delivered.size(); i++) begin
            checkOutput("rnd_order", 32'(delivered[i]), 32'(sent[i]));
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
